// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// datapath mux selects and the packed control word driven by the sequencer.
package multicycle_control_fsm_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    localparam logic       ALU_SRC_A_PC    = 1'b0;
    localparam logic       ALU_SRC_A_REG   = 1'b1;
    localparam logic [1:0] ALU_SRC_B_REG   = 2'd0;
    localparam logic [1:0] ALU_SRC_B_FOUR  = 2'd1;
    localparam logic [1:0] ALU_SRC_B_IMM   = 2'd2;
    localparam logic [1:0] ALU_CTRL_ADD    = 2'd0;
    localparam logic [1:0] ALU_CTRL_FUNCT  = 2'd1;
    localparam logic [1:0] ALU_CTRL_BRANCH = 2'd2;
    localparam logic       PCSRC_ALU       = 1'b0;
    localparam logic       PCSRC_ALUOUT    = 1'b1;
    localparam logic [1:0] WBSEL_ALUOUT    = 2'd0;
    localparam logic [1:0] WBSEL_MDR       = 2'd1;
    localparam logic [1:0] WBSEL_ALU       = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mdr_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ctrl_sel;
        logic       pc_source;
        logic       reg_write;
        logic [1:0] wb_sel;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// Combinational half of the sequencer: current state plus instruction/handshake
// conditions produce the next state and the full datapath control word.
module mc_output_decode
    import multicycle_control_fsm_pkg::*;
(
    input  logic       run,
    input  logic [2:0] state,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       ecall_halt,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output state_t     state_next
);

    always_comb begin
        ctrl       = '0;
        state_next = S_IF;
        if (run) begin
            case (state)
                S_IF: begin
                    ctrl.mem_read = 1'b1;
                    if (mem_ready) begin
                        ctrl.ir_write = 1'b1;
                        state_next    = S_ID;
                    end else begin
                        state_next    = S_IF;
                    end
                end
                S_ID: begin
                    // Precompute PC+imm into ALUOut for branch/JAL targets.
                    ctrl.alu_src_a    = ALU_SRC_A_PC;
                    ctrl.alu_src_b    = ALU_SRC_B_IMM;
                    ctrl.alu_ctrl_sel = ALU_CTRL_ADD;
                    state_next        = S_EX;
                    if (opcode == OP_ECALL) begin
                        if (ecall_halt) begin
                            state_next = S_HALT;
                        end else begin
                            ctrl.alu_src_b = ALU_SRC_B_FOUR;
                            ctrl.pc_write  = 1'b1;
                            ctrl.pc_source = PCSRC_ALU;
                            state_next     = S_IF;
                        end
                    end
                end
                S_EX: begin
                    state_next = S_WB;
                    case (opcode)
                        OP_R: begin
                            ctrl.alu_src_a    = ALU_SRC_A_REG;
                            ctrl.alu_src_b    = ALU_SRC_B_REG;
                            ctrl.alu_ctrl_sel = ALU_CTRL_FUNCT;
                        end
                        OP_I: begin
                            ctrl.alu_src_a    = ALU_SRC_A_REG;
                            ctrl.alu_src_b    = ALU_SRC_B_IMM;
                            ctrl.alu_ctrl_sel = ALU_CTRL_FUNCT;
                        end
                        OP_LD, OP_ST, OP_JALR: begin
                            ctrl.alu_src_a    = ALU_SRC_A_REG;
                            ctrl.alu_src_b    = ALU_SRC_B_IMM;
                            ctrl.alu_ctrl_sel = ALU_CTRL_ADD;
                            if (opcode != OP_JALR) state_next = S_MEM;
                        end
                        OP_BR: begin
                            ctrl.alu_src_a    = ALU_SRC_A_REG;
                            ctrl.alu_src_b    = ALU_SRC_B_REG;
                            ctrl.alu_ctrl_sel = ALU_CTRL_BRANCH;
                            if (alu_bcond) begin
                                ctrl.pc_write  = 1'b1;
                                ctrl.pc_source = PCSRC_ALUOUT;
                                state_next     = S_IF;
                            end
                        end
                        OP_JAL: begin
                            ctrl.alu_src_a    = ALU_SRC_A_PC;
                            ctrl.alu_src_b    = ALU_SRC_B_FOUR;
                            ctrl.alu_ctrl_sel = ALU_CTRL_ADD;
                            ctrl.reg_write    = 1'b1;
                            ctrl.wb_sel       = WBSEL_ALU;
                            ctrl.pc_write     = 1'b1;
                            ctrl.pc_source    = PCSRC_ALUOUT;
                            state_next        = S_IF;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    ctrl.i_or_d    = 1'b1;
                    ctrl.mem_read  = (opcode == OP_LD);
                    ctrl.mem_write = (opcode == OP_ST);
                    if (mem_ready) begin
                        ctrl.mdr_write = (opcode == OP_LD);
                        state_next     = S_WB;
                    end else begin
                        state_next     = S_MEM;
                    end
                end
                S_WB: begin
                    ctrl.alu_src_a    = ALU_SRC_A_PC;
                    ctrl.alu_src_b    = ALU_SRC_B_FOUR;
                    ctrl.alu_ctrl_sel = ALU_CTRL_ADD;
                    ctrl.pc_write     = 1'b1;
                    ctrl.pc_source    = (opcode == OP_JALR) ? PCSRC_ALUOUT : PCSRC_ALU;
                    case (opcode)
                        OP_R, OP_I: begin
                            ctrl.reg_write = 1'b1;
                            ctrl.wb_sel    = WBSEL_ALUOUT;
                        end
                        OP_LD: begin
                            ctrl.reg_write = 1'b1;
                            ctrl.wb_sel    = WBSEL_MDR;
                        end
                        OP_JALR: begin
                            ctrl.reg_write = 1'b1;
                            ctrl.wb_sel    = WBSEL_ALU;
                        end
                        default: ;
                    endcase
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_IF;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: state register, sticky halt flag and
// retired-instruction counter around the combinational control decoder.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             alu_bcond,
    input  logic             ecall_halt,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_ctrl_sel,
    output logic             pc_source,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             is_halted,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] retired
);

    logic [2:0]       state_reg;
    state_t           state_next;
    logic             halted_reg;
    logic [CNT_W-1:0] retired_reg;
    ctrl_t            ctrl;

    mc_output_decode u_decode (
        .run        (reset),
        .state      (state_reg),
        .opcode     (opcode),
        .alu_bcond  (alu_bcond),
        .ecall_halt (ecall_halt),
        .mem_ready  (mem_ready),
        .ctrl       (ctrl),
        .state_next (state_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_IF;
            halted_reg  <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_HALT) halted_reg <= 1'b1;
            // Every PC load marks the end of one instruction.
            if (ctrl.pc_write) retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign ir_write     = ctrl.ir_write;
    assign mdr_write    = ctrl.mdr_write;
    assign i_or_d       = ctrl.i_or_d;
    assign mem_read     = ctrl.mem_read;
    assign mem_write    = ctrl.mem_write;
    assign alu_src_a    = ctrl.alu_src_a;
    assign alu_src_b    = ctrl.alu_src_b;
    assign alu_ctrl_sel = ctrl.alu_ctrl_sel;
    assign pc_source    = ctrl.pc_source;
    assign reg_write    = ctrl.reg_write;
    assign wb_sel       = ctrl.wb_sel;
    assign is_halted    = halted_reg;
    assign state_out    = state_reg;
    assign retired      = retired_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is expanded into a queue of
// expected per-cycle (state, control word) steps, then driven in lockstep.
module tb_multicycle_control_fsm;

    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011, BR_OP = 7'b1100011, JAL_OP = 7'b1101111;
    localparam logic [6:0] JALR_OP = 7'b1100111, EC_OP = 7'b1110011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode = '0;
    logic        alu_bcond = 1'b0, ecall_halt = 1'b0, mem_ready = 1'b0;
    logic        pc_write, ir_write, mdr_write, i_or_d, mem_read, mem_write;
    logic        alu_src_a, pc_source, reg_write, is_halted;
    logic [1:0]  alu_src_b, alu_ctrl_sel, wb_sel;
    logic [2:0]  state_out;
    logic [31:0] retired;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond),
        .ecall_halt(ecall_halt), .mem_ready(mem_ready), .pc_write(pc_write),
        .ir_write(ir_write), .mdr_write(mdr_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl_sel(alu_ctrl_sel), .pc_source(pc_source),
        .reg_write(reg_write), .wb_sel(wb_sel), .is_halted(is_halted),
        .state_out(state_out), .retired(retired)
    );

    wire [14:0] ctl_obs = {pc_write, ir_write, mdr_write, i_or_d, mem_read, mem_write,
                           alu_src_a, alu_src_b, alu_ctrl_sel, pc_source, reg_write, wb_sel};

    typedef struct {
        int          st;
        bit          rdy;
        bit          bc;
        bit          eh;
        logic [6:0]  op;
        logic [14:0] ctl;
    } step_t;

    step_t       plan[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned model_retired = 0;

    function automatic logic [14:0] cw(bit pcw, bit irw, bit mdrw, bit iord, bit mr, bit mw,
                                       bit sa, logic [1:0] sb, logic [1:0] ac, bit ps,
                                       bit rw, logic [1:0] wb);
        return {pcw, irw, mdrw, iord, mr, mw, sa, sb, ac, ps, rw, wb};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(int st, bit rdy, bit bc, bit eh, logic [6:0] op, logic [14:0] ctl);
        step_t e;
        e.st = st; e.rdy = rdy; e.bc = bc; e.eh = eh; e.op = op; e.ctl = ctl;
        plan.push_back(e);
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, derived from its class.
    task automatic plan_instr(logic [6:0] op, bit bc, bit eh, int if_stall, int mem_stall);
        bit is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_ec, exbc, ideh;
        logic [6:0] junk;
        logic [1:0] wb;
        is_r = (op == R_OP); is_i = (op == I_OP); is_ld = (op == LD_OP); is_st = (op == ST_OP);
        is_br = (op == BR_OP); is_jal = (op == JAL_OP); is_jalr = (op == JALR_OP);
        is_ec = (op == EC_OP);
        for (int k = 0; k < if_stall; k++) begin
            junk = 7'($urandom);
            push(0, 0, rb(), rb(), junk, cw(0,0,0,0,1,0,0,0,0,0,0,0));
        end
        junk = 7'($urandom);
        push(0, 1, rb(), rb(), junk, cw(0,1,0,0,1,0,0,0,0,0,0,0));
        ideh = is_ec ? eh : rb();
        if (is_ec && eh) begin
            push(1, rb(), rb(), ideh, op, cw(0,0,0,0,0,0,0,2,0,0,0,0));
            return;
        end
        if (is_ec) begin
            push(1, rb(), rb(), ideh, op, cw(1,0,0,0,0,0,0,1,0,0,0,0));
            return;
        end
        push(1, rb(), rb(), ideh, op, cw(0,0,0,0,0,0,0,2,0,0,0,0));
        exbc = is_br ? bc : rb();
        if (is_r)                          push(2, rb(), exbc, rb(), op, cw(0,0,0,0,0,0,1,0,1,0,0,0));
        else if (is_i)                     push(2, rb(), exbc, rb(), op, cw(0,0,0,0,0,0,1,2,1,0,0,0));
        else if (is_ld || is_st || is_jalr) push(2, rb(), exbc, rb(), op, cw(0,0,0,0,0,0,1,2,0,0,0,0));
        else if (is_br && bc) begin
            push(2, rb(), exbc, rb(), op, cw(1,0,0,0,0,0,1,0,2,1,0,0));
            return;
        end
        else if (is_br)                    push(2, rb(), exbc, rb(), op, cw(0,0,0,0,0,0,1,0,2,0,0,0));
        else if (is_jal) begin
            push(2, rb(), exbc, rb(), op, cw(1,0,0,0,0,0,0,1,0,1,1,2));
            return;
        end
        else                               push(2, rb(), exbc, rb(), op, cw(0,0,0,0,0,0,0,0,0,0,0,0));
        if (is_ld || is_st) begin
            for (int k = 0; k < mem_stall; k++)
                push(3, 0, rb(), rb(), op, cw(0,0,0,1,is_ld,is_st,0,0,0,0,0,0));
            push(3, 1, rb(), rb(), op, cw(0,0,is_ld,1,is_ld,is_st,0,0,0,0,0,0));
        end
        wb = is_ld ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        push(4, rb(), rb(), rb(), op,
             cw(1,0,0,0,0,0,0,1,0,is_jalr, is_r || is_i || is_ld || is_jalr, wb));
    endtask

    task automatic run_plan(string tag);
        step_t e;
        int    n;
        n = 0;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            @(negedge clk);
            opcode = e.op; alu_bcond = e.bc; ecall_halt = e.eh; mem_ready = e.rdy;
            #1;
            chk($sformatf("%s_c%0d_state", tag, n), 32'(state_out), 32'(e.st));
            chk($sformatf("%s_c%0d_ctl", tag, n), 32'(ctl_obs), 32'(e.ctl));
            if (e.ctl[14]) model_retired++;
            n++;
        end
        @(posedge clk);
        #1;
        chk({tag, "_retired"}, retired, model_retired);
    endtask

    initial begin
        logic [6:0] ops[8];
        logic [6:0] op;
        ops = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JALR_OP, EC_OP};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl_forced", 32'(ctl_obs), 32'd0);
        @(posedge clk); #1;
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_halted", 32'(is_halted), 32'd0);
        chk("reset_retired", retired, 32'd0);
        @(negedge clk); reset = 1'b1; mem_ready = 1'b0;

        plan_instr(R_OP, 0, 0, 0, 0);     run_plan("add");
        plan_instr(LD_OP, 0, 0, 0, 2);    run_plan("lw_stall");
        plan_instr(BR_OP, 1, 0, 0, 0);    run_plan("beq_taken");
        plan_instr(BR_OP, 0, 0, 0, 0);    run_plan("beq_not");
        plan_instr(JAL_OP, 0, 0, 0, 0);   run_plan("jal");
        plan_instr(JALR_OP, 0, 0, 1, 0);  run_plan("jalr");
        plan_instr(ST_OP, 0, 0, 2, 1);    run_plan("sw");
        plan_instr(I_OP, 0, 0, 0, 0);     run_plan("addi");
        plan_instr(EC_OP, 0, 0, 0, 0);    run_plan("ecall_cont");
        plan_instr(7'b0000000, 0, 0, 0, 0); run_plan("nop0");

        for (int i = 0; i < 150; i++) begin
            int idx;
            idx = $urandom_range(0, 8);
            if (idx == 8) begin
                op = 7'($urandom);
                foreach (ops[j]) if (ops[j] == op) op = 7'b1111111;
            end else begin
                op = ops[idx];
            end
            plan_instr(op, rb(), 1'b0, $urandom_range(0, 2), $urandom_range(0, 2));
            run_plan($sformatf("rnd%0d", i));
        end

        plan_instr(EC_OP, 0, 1, 0, 0);    run_plan("ecall_halt");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            opcode = 7'($urandom); alu_bcond = rb(); ecall_halt = rb(); mem_ready = rb();
            #1;
            chk($sformatf("halt%0d_state", i), 32'(state_out), 32'd5);
            chk($sformatf("halt%0d_ctl", i), 32'(ctl_obs), 32'd0);
            chk($sformatf("halt%0d_retired", i), retired, model_retired);
            if (i > 0) chk($sformatf("halt%0d_flag", i), 32'(is_halted), 32'd1);
        end
        @(negedge clk); reset = 1'b0; mem_ready = 1'b1;
        #1;
        chk("halt_reset_ctl", 32'(ctl_obs), 32'd0);
        @(posedge clk); #1;
        model_retired = 0;
        chk("halt_reset_state", 32'(state_out), 32'd0);
        chk("halt_reset_flag", 32'(is_halted), 32'd0);
        chk("halt_reset_retired", retired, 32'd0);
        @(negedge clk); reset = 1'b1; mem_ready = 1'b0;

        plan_instr(R_OP, 0, 0, 0, 0);     run_plan("post_halt_add");
        plan_instr(ST_OP, 0, 0, 0, 1);
        void'(plan.pop_back());
        void'(plan.pop_back());
        run_plan("sw_cut");
        @(negedge clk); reset = 1'b0; mem_ready = 1'b1; opcode = ST_OP;
        #1;
        chk("midmem_mem_write", 32'(mem_write), 32'd0);
        chk("midmem_ctl", 32'(ctl_obs), 32'd0);
        @(posedge clk); #1;
        model_retired = 0;
        chk("midmem_state", 32'(state_out), 32'd0);
        chk("midmem_retired", retired, 32'd0);
        @(negedge clk); reset = 1'b1; mem_ready = 1'b0;
        plan_instr(7'b0000000, 0, 0, 0, 0); run_plan("nop_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
